// File: rtl/core_pkg.sv
// Shared core definitions: sequencer states and default widths/codes
// used by the sequencer, decoder and instruction ROM.
package core_pkg;

  localparam int SEQ_PC_W = 10;
  localparam int SEQ_INSTR_W = 9;
  localparam logic [8:0] SEQ_HALT_CODE = 9'h1FF;
  localparam int SEQ_MEM_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MWAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/prog_sequencer_pc_reg.sv
// pc_reg: program counter with clear, absolute load and increment.
// Ports: clk, reset, clr, inc, load, d -> pc, sticky wrap flag.
module pc_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] pc,
  output logic         wrap
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      pc <= d;
    end else if (inc) begin
      pc <= pc + 1'b1;
      if (&pc) wrap <= 1'b1;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: multi-cycle FETCH/EXEC/MWAIT sequencer with PC and
// write-strobe gating. Ports: Clk, Reset, start, instr, decoder flags,
// br_taken/br_target -> PC, fetch_en, reg_we, mem_we, busy, done,
// pc_wrap. Macro PROG_SEQUENCER_ICOUNT_EN adds icount[15:0].
import core_pkg::*;

module prog_sequencer #(
  parameter int PC_W = SEQ_PC_W,
  parameter int INSTR_W = SEQ_INSTR_W,
  parameter logic [INSTR_W-1:0] HALT_CODE = INSTR_W'(SEQ_HALT_CODE),
  parameter int MEM_LAT = SEQ_MEM_LAT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               Branch,
  input  logic               MemWrite,
  input  logic               RegWrite,
  input  logic               MemtoReg,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [PC_W-1:0]    PC,
  output logic               fetch_en,
  output logic               reg_we,
  output logic               mem_we,
  output logic               busy,
  output logic               done,
  output logic               pc_wrap
`ifdef PROG_SEQUENCER_ICOUNT_EN
  ,
  output logic [15:0]        icount
`endif
);

  localparam logic [2:0] LAT_M1 =
    (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

  seq_state_t state;
  logic [2:0] cnt;
  logic halt, ld_wait, exec_go, mw_last;
  logic retire, pc_load, pc_inc, pc_clr;

  assign halt    = (instr == HALT_CODE);
  assign ld_wait = MemtoReg && (MEM_LAT > 0);
  assign exec_go = (state == EXEC) && !halt && !ld_wait;
  assign mw_last = (state == MWAIT) && (cnt == 3'd0);
  assign retire  = exec_go || mw_last;
  assign pc_load = exec_go && Branch && br_taken;
  assign pc_inc  = retire && !pc_load;
  assign pc_clr  = (state == IDLE) && start;

  // A store wins over a stray RegWrite so the strobes never overlap.
  assign reg_we = (exec_go && RegWrite && !MemWrite) || mw_last;
  assign mem_we = exec_go && MemWrite;

  pc_reg #(.W(PC_W)) u_pc (
    .clk   (Clk),
    .reset (Reset),
    .clr   (pc_clr),
    .inc   (pc_inc),
    .load  (pc_load),
    .d     (br_target),
    .pc    (PC),
    .wrap  (pc_wrap)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      fetch_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            fetch_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          state    <= EXEC;
          fetch_en <= 1'b0;
        end
        EXEC: begin
          if (halt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (ld_wait) begin
            state <= MWAIT;
            cnt   <= LAT_M1;
          end else begin
            state    <= FETCH;
            fetch_en <= 1'b1;
          end
        end
        MWAIT: begin
          if (cnt == 3'd0) begin
            state    <= FETCH;
            fetch_en <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          fetch_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROG_SEQUENCER_ICOUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset || pc_clr) begin
      icount <= '0;
    end else if (retire && icount != 16'hFFFF) begin
      icount <= icount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: ROM/ALU environment, trace-based program
// model, directed scenarios and randomized programs.
module tb_prog_sequencer;

  localparam int LAT = 3;
  localparam logic [8:0] HALT = 9'h1FF;

  logic       Clk, Reset, start;
  logic [8:0] instr;
  logic       Branch, MemWrite, RegWrite, MemtoReg, br_taken;
  logic [9:0] br_target, PC;
  logic       fetch_en, reg_we, mem_we, busy, done, pc_wrap;
`ifdef PROG_SEQUENCER_ICOUNT_EN
  logic [15:0] icount;
`endif

  prog_sequencer #(.MEM_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .instr(instr),
    .Branch(Branch), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .br_taken(br_taken),
    .br_target(br_target), .PC(PC), .fetch_en(fetch_en),
    .reg_we(reg_we), .mem_we(mem_we), .busy(busy), .done(done),
    .pc_wrap(pc_wrap)
`ifdef PROG_SEQUENCER_ICOUNT_EN
    , .icount(icount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM contents; rom_tk means "branch taken on first visit only".
  logic [8:0] rom_ins [1024];
  logic [9:0] rom_tg  [1024];
  bit rom_br [1024];
  bit rom_mw [1024];
  bit rom_rw [1024];
  bit rom_mr [1024];
  bit rom_tk [1024];
  int nvis [1024];
  bit vis_clr;

  always_comb begin
    instr     = rom_ins[PC];
    Branch    = rom_br[PC];
    MemWrite  = rom_mw[PC];
    RegWrite  = rom_rw[PC];
    MemtoReg  = rom_mr[PC];
    br_target = rom_tg[PC];
    br_taken  = rom_tk[PC] && (nvis[PC] <= 1);
  end

  always @(posedge Clk) begin
    if (vis_clr) begin
      foreach (nvis[i]) nvis[i] <= 0;
    end else if (fetch_en) begin
      nvis[PC] <= nvis[PC] + 1;
    end
  end

  typedef struct {
    int pc; bit fe; bit rw; bit mw; bit bz; bit dn; bit wr; int ic;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int m_pc = 0, m_ic = 0, last_body, rw_cnt, done_at;
  bit m_wrap = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, expv);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) begin
      rom_ins[i] = 9'h000; rom_tg[i] = 10'h000;
      rom_br[i] = 0; rom_mw[i] = 0; rom_rw[i] = 0;
      rom_mr[i] = 0; rom_tk[i] = 0;
    end
  endtask

  task automatic push(input int p, input bit fe, input bit rw,
                      input bit mw, input bit bz, input bit dn,
                      input bit wr, input int ic);
    exp_t e;
    e.pc = p; e.fe = fe; e.rw = rw; e.mw = mw;
    e.bz = bz; e.dn = dn; e.wr = wr; e.ic = ic;
    exp_q.push_back(e);
  endtask

  // Program-level model: walk the ROM instruction by instruction and
  // emit the expected per-cycle outputs of the whole run.
  task automatic gen(input int hold, output int body);
    int vis[1024];
    int p, nxt, ic, steps;
    bit w, tk;
    foreach (vis[i]) vis[i] = 0;
    push(m_pc, 0, 0, 0, 0, 0, m_wrap, m_ic);
    p = 0; w = 0; ic = 0; body = 0; steps = 0;
    forever begin
      steps++;
      if (steps > 2000) rom_ins[p] = HALT;
      vis[p]++;
      push(p, 1, 0, 0, 1, 0, w, ic);
      body++;
      if (rom_ins[p] == HALT) begin
        push(p, 0, 0, 0, 1, 0, w, ic);
        body++;
        break;
      end
      if (rom_mr[p]) begin
        push(p, 0, 0, 0, 1, 0, w, ic);
        for (int k = 1; k <= LAT; k++)
          push(p, 0, k == LAT, 0, 1, 0, w, ic);
        body += 1 + LAT;
        tk = 0;
      end else begin
        tk = rom_br[p] && rom_tk[p] && vis[p] == 1;
        push(p, 0, rom_rw[p] && !rom_mw[p], rom_mw[p], 1, 0, w, ic);
        body++;
      end
      if (tk) nxt = int'(rom_tg[p]);
      else if (p == 1023) begin nxt = 0; w = 1; end
      else nxt = p + 1;
      if (ic < 65535) ic++;
      p = nxt;
    end
    repeat (hold) push(p, 0, 0, 0, 0, 1, w, ic);
    push(p, 0, 0, 0, 0, 0, w, ic);
    m_pc = p; m_wrap = w; m_ic = ic;
  endtask

  task automatic cmp(input exp_t e, input int n);
    chk($sformatf("pc@%0d", n), int'(PC), e.pc);
    chk($sformatf("fetch_en@%0d", n), int'(fetch_en), int'(e.fe));
    chk($sformatf("reg_we@%0d", n), int'(reg_we), int'(e.rw));
    chk($sformatf("mem_we@%0d", n), int'(mem_we), int'(e.mw));
    chk($sformatf("busy@%0d", n), int'(busy), int'(e.bz));
    chk($sformatf("done@%0d", n), int'(done), int'(e.dn));
    chk($sformatf("pc_wrap@%0d", n), int'(pc_wrap), int'(e.wr));
`ifdef PROG_SEQUENCER_ICOUNT_EN
    chk($sformatf("icount@%0d", n), int'(icount), e.ic);
`endif
  endtask

  // Entered just after a rising edge with the DUT idle.
  task automatic run_prog(input int hold);
    int body, n;
    exp_t e;
    gen(hold, body);
    last_body = body;
    rw_cnt = 0; done_at = -1; n = 0;
    start = 1; vis_clr = 1;
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      e = exp_q.pop_front();
      cmp(e, n);
      if (reg_we) rw_cnt++;
      if (done && done_at < 0) done_at = n;
      @(posedge Clk); #1;
      vis_clr = 0;
      n++;
      if (n == body + hold) start = 0;
    end
  endtask

  task automatic reset_pulse();
    Reset = 1;
    @(posedge Clk); #1;
    Reset = 0;
  endtask

  initial begin
    Reset = 1; start = 0; vis_clr = 0;
    clear_rom();
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("rst_pc", int'(PC), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fetch", int'(fetch_en), 0);
    chk("rst_wrap", int'(pc_wrap), 0);
    chk("rst_we", int'(reg_we | mem_we), 0);
    @(posedge Clk); #1;
    Reset = 0;

    // rxor, and, HALT; start held 5 cycles in DONE
    clear_rom();
    rom_ins[0] = 9'h0A3; rom_rw[0] = 1;
    rom_ins[1] = 9'h051; rom_rw[1] = 1;
    rom_ins[2] = HALT;
    run_prog(5);
    chk("s1_body", last_body, 6);
    chk("s1_done_cycle", done_at, 7);
    chk("s1_regwe_pulses", rw_cnt, 2);
    chk("s1_wrap", int'(pc_wrap), 0);
    chk("s1_pc", int'(PC), 2);
`ifdef PROG_SEQUENCER_ICOUNT_EN
    chk("s1_icount", int'(icount), 2);
`endif

    // branch, load at 4, not-taken branch, store at 7, taken branch
    clear_rom();
    rom_br[0] = 1; rom_tk[0] = 1; rom_tg[0] = 10'h004;
    rom_mr[4] = 1; rom_rw[4] = 1;
    rom_br[5] = 1; rom_tk[5] = 0; rom_tg[5] = 10'h3F0;
    rom_rw[6] = 1;
    rom_mw[7] = 1;
    rom_br[8] = 1; rom_tk[8] = 1; rom_tg[8] = 10'h3F0;
    rom_ins[10'h3F0] = HALT;
    run_prog(2);
    chk("s2_body", last_body, 17);
    chk("s2_regwe_pulses", rw_cnt, 2);
    chk("s2_pc", int'(PC), 10'h3F0);

    // wrap past 0x3FF, then halt at 1
    clear_rom();
    rom_br[0] = 1; rom_tk[0] = 1; rom_tg[0] = 10'h3FE;
    rom_rw[10'h3FE] = 1;
    rom_rw[10'h3FF] = 1;
    rom_ins[1] = HALT;
    run_prog(1);
    chk("s3_body", last_body, 10);
    chk("s3_wrap", int'(pc_wrap), 1);
    chk("s3_pc", int'(PC), 1);
    reset_pulse();
    @(negedge Clk);
    chk("s3_rst_wrap", int'(pc_wrap), 0);
    chk("s3_rst_pc", int'(PC), 0);
    @(posedge Clk); #1;
    m_pc = 0; m_wrap = 0; m_ic = 0;
    run_prog(1);
    chk("s3b_wrap", int'(pc_wrap), 1);

    // reset during the load wait drops the pending write
    clear_rom();
    rom_rw[0] = 1;
    rom_mr[1] = 1; rom_rw[1] = 1;
    rw_cnt = 0;
    start = 1; vis_clr = 1;
    @(posedge Clk); #1;
    vis_clr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (reg_we) rw_cnt++;
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    chk("mw_busy", int'(busy), 1);
    chk("mw_pc", int'(PC), 1);
    chk("mw_regwe", int'(reg_we), 0);
    Reset = 1; start = 0;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("mwrst_pc", int'(PC), 0);
    chk("mwrst_busy", int'(busy), 0);
    chk("mwrst_regwe", int'(reg_we), 0);
    chk("mwrst_fetch", int'(fetch_en), 0);
    chk("mwrst_wrap", int'(pc_wrap), 0);
    chk("mwrst_pulses", rw_cnt, 1);
    @(posedge Clk); #1;
    Reset = 0;
    m_pc = 0; m_wrap = 0; m_ic = 0;

    // randomized programs
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < 1024; p++) begin
        if ($urandom_range(0, 8) == 0) rom_ins[p] = HALT;
        else rom_ins[p] = 9'($urandom_range(0, 510));
        rom_br[p] = ($urandom_range(0, 3) == 0);
        rom_tk[p] = $urandom_range(0, 1) == 1;
        rom_tg[p] = 10'($urandom_range(0, 1023));
        rom_mw[p] = ($urandom_range(0, 2) == 0);
        rom_rw[p] = ($urandom_range(0, 2) != 0);
        rom_mr[p] = ($urandom_range(0, 3) == 0);
      end
      run_prog($urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
